c17_lfsr_tpg: RTL and testbench
===============================

Name: c17_lfsr_tpg

Overview:
- Built-in test pattern generator that sits directly upstream of the c17 benchmark core.
- Replaces file-driven stimulus with an on-chip maximal-length LFSR sequence, one 5-bit vector per accepted transfer.
- Vectors are presented over a valid/ready handshake to the pattern-apply stage that drives N1, N2, N3, N6 and N7.
- Counts issued patterns and flags completion for the BIST controller.

Parameters:
- WIDTH, 5: pattern width; bit 4..0 maps to N1, N2, N3, N6, N7.
- POLY, 5'b10100: feedback tap mask (x^5+x^3+1, maximal length 31).
- SEED, 5'b00001: LFSR value loaded on start; an all-zero SEED is replaced by 5'b00001.
- NUM_PATTERNS, 31: patterns issued per run; legal range 0..2^CNTW-1.
- CNTW, 6: width of the pattern counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled in IDLE and DONE only.
- abort  input  1  terminate the current run; sampled in RUN only.
- pat_ready  input  1  downstream stage accepts pat_data this cycle.
- pat_valid  output  1  pat_data holds a valid vector.
- pat_data  output  WIDTH  current LFSR vector.
- pat_cnt  output  CNTW  number of patterns accepted in this run.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, lfsr=0, pat_cnt=0, pat_valid=0, busy=0, done=0. pat_data=0.
- Reset mid-run aborts immediately with the same values; no partial transfer is counted.
- LFSR step (Fibonacci, shift-left):
  - next = {lfsr[WIDTH-2:0], ^(lfsr & POLY)}.
  - Advances only on a handshake (pat_valid && pat_ready).
  - The all-zero state is unreachable once seeded.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from registered state only; no combinational path from pat_ready to pat_valid.
- IDLE:
  - start=1 at edge k: lfsr<=SEED (or 1 if SEED==0), pat_cnt<=0.
  - Next state is RUN; if NUM_PATTERNS==0, it goes straight to DONE.
  - pat_valid is high in the cycle after edge k (latency 1).
- RUN:
  - pat_valid=1, busy=1, pat_data=lfsr.
  - pat_data is held stable while pat_ready=0.
  - On a handshake: lfsr<=next and pat_cnt<=pat_cnt+1.
  - If pat_cnt==NUM_PATTERNS-1 at the handshake, state<=DONE.
  - start is ignored in RUN.
- Abort in RUN:
  - abort=1 forces state<=IDLE and pat_valid drops on the next cycle.
  - If a handshake occurs in the same cycle, the transfer is complete and counted (pat_cnt increments), then the block goes to IDLE.
  - Abort takes priority over the DONE transition.
- DONE:
  - done=1, pat_valid=0, pat_cnt holds its final value, lfsr holds.
  - start=1 restarts exactly as from IDLE: reseed, counter cleared, done drops next cycle.
  - abort is ignored in DONE.
- Sequence wrap: for NUM_PATTERNS > 31 the sequence repeats with period 31. pat_cnt counts on, with no saturation within the legal range.
- pat_cnt arithmetic is unsigned, width CNTW.

Test Plan:
- Reset, then start pulse with pat_ready=1 constant:
  - pat_data sequence 00001, 00010, 00100, 01001, 10010, 00101, 01011, 10110, ...
  - 31 distinct nonzero values in total.
  - done rises the cycle after the 31st handshake; pat_cnt=31.
- Backpressure: pat_ready toggling 0,0,1,0,1 during RUN.
  - pat_data stays constant across all pat_ready=0 cycles.
  - pat_cnt increments only on the two ready cycles.
  - No vector is skipped or duplicated.
- Abort after 4 handshakes, with pat_ready=1 in the abort cycle.
  - pat_cnt=5, state returns to IDLE, pat_valid=0 next cycle, done stays 0.
  - A following start reseeds to 00001.
- NUM_PATTERNS=0: start moves IDLE to DONE in one cycle, with no pat_valid pulse and pat_cnt=0.
  - SEED=0 override: first pat_data is 00001.
- Reset asserted asynchronously mid-RUN, between clock edges:
  - pat_valid, busy, done and pat_cnt go to 0 immediately.
  - After release, the block stays in IDLE until start.
- NUM_PATTERNS=35 with pat_ready=1:
  - Handshake 32 repeats 00001 (wrap).
  - done is asserted after 35 handshakes with pat_cnt=35.

Source files
------------

// File: rtl/c17_lfsr_tpg.sv
// Built-in test pattern generator for the c17 core: a maximal-length LFSR
// feeding 5-bit vectors over valid/ready, with a per-run pattern counter.
module c17_lfsr_tpg #(
    parameter int unsigned      WIDTH        = 5,
    parameter logic [WIDTH-1:0] POLY         = 5'b10100,
    parameter logic [WIDTH-1:0] SEED         = 5'b00001,
    parameter int unsigned      NUM_PATTERNS = 31,
    parameter int unsigned      CNTW         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pat_ready,
    output logic             pat_valid,
    output logic [WIDTH-1:0] pat_data,
    output logic [CNTW-1:0]  pat_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [CNTW-1:0]  LAST_CNT = CNTW'(NUM_PATTERNS - 1);
    localparam state_t           START_ST = (NUM_PATTERNS == 0) ? ST_DONE : ST_RUN;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             handshake;
    logic             fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        fb        = ^(lfsr_q & POLY);
        handshake = (state_q == ST_RUN) && pat_ready;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_d  = SEED_EFF;
                    cnt_d   = '0;
                    state_d = START_ST;
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                    cnt_d  = cnt_q + CNTW'(1);
                end
                // A transfer in the abort cycle still completes and is counted.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (handshake && (cnt_q == LAST_CNT)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pat_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pat_data  = lfsr_q;
    assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_c17_lfsr_tpg.sv
// Bench for c17_lfsr_tpg: four instances (default, NUM_PATTERNS=0, SEED=0,
// NUM_PATTERNS=35) share stimulus and are checked against a bit-stream model.
module tb_c17_lfsr_tpg;

    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    localparam int          NP[4] = '{31, 0, 3, 35};
    localparam logic [4:0]  SD[4] = '{5'd1, 5'd1, 5'd0, 5'd1};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, abort = 1'b0, pat_ready = 1'b0;
    logic       v[4], b[4], dn[4];
    logic [4:0] d[4];
    logic [5:0] c[4];

    int total = 0, bad = 0;
    int m_st[4] = '{0, 0, 0, 0};
    int m_k[4]  = '{0, 0, 0, 0};
    bit m_seeded[4] = '{0, 0, 0, 0};
    logic [4:0] q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;

    c17_lfsr_tpg #(.SEED(5'd1), .NUM_PATTERNS(31)) u0 (.clk(clk), .rst_n(rst_n), .start(start),
        .abort(abort), .pat_ready(pat_ready), .pat_valid(v[0]), .pat_data(d[0]), .pat_cnt(c[0]),
        .busy(b[0]), .done(dn[0]));
    c17_lfsr_tpg #(.SEED(5'd1), .NUM_PATTERNS(0)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
        .abort(abort), .pat_ready(pat_ready), .pat_valid(v[1]), .pat_data(d[1]), .pat_cnt(c[1]),
        .busy(b[1]), .done(dn[1]));
    c17_lfsr_tpg #(.SEED(5'd0), .NUM_PATTERNS(3)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
        .abort(abort), .pat_ready(pat_ready), .pat_valid(v[2]), .pat_data(d[2]), .pat_cnt(c[2]),
        .busy(b[2]), .done(dn[2]));
    c17_lfsr_tpg #(.SEED(5'd1), .NUM_PATTERNS(35)) u3 (.clk(clk), .rst_n(rst_n), .start(start),
        .abort(abort), .pat_ready(pat_ready), .pat_valid(v[3]), .pat_data(d[3]), .pat_cnt(c[3]),
        .busy(b[3]), .done(dn[3]));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Pattern k of a run is the 5-bit window s[k..k+4] of the sequence
    // s[n+5] = s[n] ^ s[n+2], whose first five bits are the seed (MSB first).
    function automatic logic [4:0] pat(input logic [4:0] sd, input int k);
        bit s[200];
        logic [4:0] r;
        for (int j = 0; j < 5; j++) s[j] = sd[4-j];
        for (int j = 5; j < 200; j++) s[j] = s[j-5] ^ s[j-3];
        for (int j = 0; j < 5; j++) r[4-j] = s[k+j];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i] <= M_IDLE; m_k[i] <= 0; m_seeded[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == M_RUN) begin
                    if (pat_ready) m_k[i] <= m_k[i] + 1;
                    if (abort) m_st[i] <= M_IDLE;
                    else if (pat_ready && (m_k[i] + 1 == NP[i])) m_st[i] <= M_DONE;
                end else if (start) begin
                    m_k[i] <= 0; m_seeded[i] <= 1'b1;
                    m_st[i] <= (NP[i] == 0) ? M_DONE : M_RUN;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic [4:0] sde, ed;
            logic [13:0] act, exp;
            sde = (SD[i] == 5'd0) ? 5'd1 : SD[i];
            ed  = m_seeded[i] ? pat(sde, m_k[i]) : 5'd0;
            exp = {m_st[i] == M_RUN, m_st[i] == M_RUN, m_st[i] == M_DONE, 6'(m_k[i]), ed};
            act = {v[i], b[i], dn[i], c[i], d[i]};
            chk($sformatf("model_u%0d", i), int'(act), int'(exp));
        end
        if (v[0] && pat_ready) q0.push_back(d[0]);
        if (v[1] && pat_ready) q1.push_back(d[1]);
        if (v[2] && pat_ready) q2.push_back(d[2]);
        if (v[3] && pat_ready) q3.push_back(d[3]);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [4:0] seq8[8] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16};
        bit seen[32];
        int ok, n;
        // Reset
        #2 rst_n = 1'b0;
        tick(2);
        chk("reset_u0", int'({v[0], b[0], dn[0], c[0], d[0]}), 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_no_valid", int'(v[0]), 0);

        // Full run with ready held high
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        pat_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        chk("latency1_valid", int'(v[0]), 1);
        chk("u1_np0_done", int'({dn[1], v[1], c[1]}), 'h80);
        n = 0;
        while (!dn[0] && n < 100) begin tick(); n++; end
        chk("u0_done_timeout", int'(dn[0]), 1);
        chk("done_after_31", q0.size(), 31);
        chk("cnt31", int'(c[0]), 31);
        for (int j = 0; j < 8; j++) chk($sformatf("seq%0d", j), int'(q0[j]), int'(seq8[j]));
        ok = 1;
        foreach (q0[j]) begin
            if (q0[j] == 5'd0 || seen[q0[j]]) ok = 0;
            seen[q0[j]] = 1'b1;
        end
        chk("distinct31", ok, 1);
        n = 0;
        while (!dn[3] && n < 20) begin tick(); n++; end
        chk("u3_done_timeout", int'(dn[3]), 1);
        chk("u3_hs35", q3.size(), 35);
        chk("u3_wrap32", int'(q3[31]), 1);
        chk("u3_cnt35", int'(c[3]), 35);
        chk("u2_seed0_first", int'(q2[0]), 1);
        chk("u1_no_valid", q1.size(), 0);

        // Backpressure
        q0.delete();
        pat_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
        foreach (seq8[j]) if (j < 5) begin
            pat_ready = (j == 2 || j == 4); tick();
        end
        pat_ready = 1'b0;
        chk("bp_cnt2", int'(c[0]), 2);
        chk("bp_data", int'(d[0]), 'h04);
        chk("bp_order", int'({q0[0], q0[1]}), 'h22);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_run", int'(c[0]), 2);

        // Abort
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", int'(v[0]), 0);
        pat_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        tick(4);
        abort = 1'b1; tick(); abort = 1'b0; pat_ready = 1'b0;
        chk("abort_cnt5", int'(c[0]), 5);
        chk("abort_flags", int'({v[0], b[0], dn[0]}), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("reseed", int'({v[0], d[0]}), 'h21);

        // Asynchronous reset mid-run
        pat_ready = 1'b1; tick(3);
        @(posedge clk); #3 rst_n = 1'b0; #1;
        chk("async_rst_u0", int'({v[0], b[0], dn[0], c[0]}), 0);
        chk("async_rst_u3", int'({v[3], b[3], dn[3], c[3]}), 0);
        @(negedge clk); rst_n = 1'b1;
        tick(3);
        chk("post_rst_idle", int'({v[0], b[0], dn[0], d[0]}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
